// File: rtl/apb_demux_pkg.sv
// Shared types and helpers for the registered APB demultiplexer.
//   state_e     : controller states (IDLE/SETUP/ACCESS/RESP/ERR)
//   apb_req_t   : default APB request struct (32-bit address/data)
//   apb_resp_t  : default APB response struct
//   apb_rule_t  : default address rule {idx, start_addr, end_addr}, end exclusive
//   cnt_width() : watchdog counter width for a given timeout
package apb_demux_pkg;

  localparam int unsigned ApbAddrWidth = 32;
  localparam int unsigned ApbDataWidth = 32;
  localparam int unsigned ApbStrbWidth = ApbDataWidth / 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_e;

  typedef struct packed {
    logic [ApbAddrWidth-1:0] paddr;
    logic [2:0]              pprot;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ApbDataWidth-1:0] pwdata;
    logic [ApbStrbWidth-1:0] pstrb;
  } apb_req_t;

  typedef struct packed {
    logic                    pready;
    logic [ApbDataWidth-1:0] prdata;
    logic                    pslverr;
  } apb_resp_t;

  typedef struct packed {
    logic [31:0]             idx;
    logic [ApbAddrWidth-1:0] start_addr;
    logic [ApbAddrWidth-1:0] end_addr;
  } apb_rule_t;

  // Width able to hold 0..timeout_cycles; at least one bit so a disabled
  // watchdog still has a legal (unused) counter.
  function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_watchdog.sv
// Access-phase watchdog for the APB demultiplexer.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   clear_i  : return the counter to zero (held outside the access phase)
//   count_i  : advance the counter by one this cycle
//   expire_o : this counting cycle is the last allowed one (combinational)
// TimeoutCycles = 0 disables expiry entirely.
module apb_watchdog
  import apb_demux_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned CntWidth = cnt_width(TimeoutCycles);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (TimeoutCycles == 0) begin : g_disabled
      assign expire_o = 1'b0;
    end else begin : g_enabled
      // The counter reads 0 in the first access cycle, so matching
      // TimeoutCycles-1 flags the TimeoutCycles-th access cycle.
      localparam logic [CntWidth-1:0] LastCnt = CntWidth'(TimeoutCycles - 1);
      assign expire_o = count_i && (cnt_q == LastCnt);
    end
  endgenerate

endmodule

// File: rtl/apb_demux_reg_to.sv
// Registered, address-decoding APB demultiplexer with decode-error responder
// and access watchdog. Every output comes from a flop, so there is no
// combinational path from the slave port to any master port.
//   clk_i       : clock
//   rst_i       : asynchronous active-high reset
//   addr_map_i  : NoRules address rules, quasi-static
//   slv_req_i   : upstream APB request
//   slv_resp_o  : upstream APB response
//   mst_req_o   : NoMstPorts downstream APB requests
//   mst_resp_i  : NoMstPorts downstream APB responses
//   dec_err_o   : one-cycle pulse when an unmapped transfer completes
//   timeout_o   : one-cycle pulse when the watchdog aborts a transfer
//   busy_o      : controller not in IDLE
//
// Handshake: upstream, a transfer is accepted when psel is seen in IDLE; the
// master must hold its request until it sees pready, which is high for exactly
// one cycle (RESP or ERR). Downstream, the selected port gets one setup cycle
// (psel=1, penable=0) then an access phase (psel=1, penable=1) that ends on
// the first cycle with pready=1, or is aborted by the watchdog.
module apb_demux_reg_to
  import apb_demux_pkg::*;
#(
  parameter int unsigned NoMstPorts    = 4,
  parameter int unsigned NoRules       = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16,
  parameter type         req_t         = apb_req_t,
  parameter type         resp_t        = apb_resp_t,
  parameter type         rule_t        = apb_rule_t
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  rule_t [((NoRules > 0) ? NoRules : 1)-1:0] addr_map_i,
  input  req_t                                     slv_req_i,
  output resp_t                                    slv_resp_o,
  output req_t  [NoMstPorts-1:0]                   mst_req_o,
  input  resp_t [NoMstPorts-1:0]                   mst_resp_i,
  output logic                                     dec_err_o,
  output logic                                     timeout_o,
  output logic                                     busy_o
);

  localparam int unsigned SelWidth = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  // ---------------------------------------------------------------------------
  // Address decode (combinational, only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic [AddrWidth-1:0] dec_addr;
  logic                 dec_hit;
  logic [SelWidth-1:0]  dec_idx;

  assign dec_addr = slv_req_i.paddr;

  // Scan from the highest rule down so the lowest matching index is the last
  // one written and wins. A rule pointing beyond the last port never matches.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = int'(NoRules) - 1; i >= 0; i--) begin
      if ((dec_addr >= addr_map_i[i].start_addr) &&
          (dec_addr <  addr_map_i[i].end_addr) &&
          (addr_map_i[i].idx < NoMstPorts)) begin
        dec_hit = 1'b1;
        dec_idx = SelWidth'(addr_map_i[i].idx);
      end
    end
  end

  // penable of the upstream request is not needed: acceptance keys on psel.
  logic unused_slv_penable;
  assign unused_slv_penable = slv_req_i.penable;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  logic [SelWidth-1:0]    sel_q;
  req_t  [NoMstPorts-1:0] mst_req_q;
  resp_t                  slv_resp_q;
  logic                   dec_err_q;
  logic                   timeout_q;
  logic                   wd_expire;
  logic [DataWidth-1:0]   sel_prdata;

  assign sel_prdata = mst_resp_i[sel_q].prdata;

  apb_watchdog #(
    .TimeoutCycles (TimeoutCycles)
  ) i_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (state_q != ACCESS),
    .count_i  (state_q == ACCESS),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      mst_req_q  <= '0;
      slv_resp_q <= '0;
      dec_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // Response and pulses are single-cycle unless loaded below.
      slv_resp_q <= '0;
      dec_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (slv_req_i.psel) begin
            if (dec_hit) begin
              sel_q                      <= dec_idx;
              mst_req_q[dec_idx].paddr   <= slv_req_i.paddr;
              mst_req_q[dec_idx].pprot   <= slv_req_i.pprot;
              mst_req_q[dec_idx].pwrite  <= slv_req_i.pwrite;
              mst_req_q[dec_idx].pwdata  <= slv_req_i.pwdata;
              mst_req_q[dec_idx].pstrb   <= slv_req_i.pstrb;
              mst_req_q[dec_idx].psel    <= 1'b1;
              mst_req_q[dec_idx].penable <= 1'b0;
              state_q                    <= SETUP;
            end else begin
              slv_resp_q.pready  <= 1'b1;
              slv_resp_q.pslverr <= 1'b1;
              dec_err_q          <= 1'b1;
              state_q            <= ERR;
            end
          end
        end
        SETUP: begin
          mst_req_q[sel_q].penable <= 1'b1;
          state_q                  <= ACCESS;
        end
        ACCESS: begin
          // A completing slave takes priority over a simultaneous expiry.
          if (mst_resp_i[sel_q].pready) begin
            slv_resp_q.pready  <= 1'b1;
            slv_resp_q.prdata  <= sel_prdata;
            slv_resp_q.pslverr <= mst_resp_i[sel_q].pslverr;
            mst_req_q          <= '0;
            state_q            <= RESP;
          end else if (wd_expire) begin
            slv_resp_q.pready  <= 1'b1;
            slv_resp_q.pslverr <= 1'b1;
            timeout_q          <= 1'b1;
            mst_req_q          <= '0;
            state_q            <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mst_req_o  = mst_req_q;
  assign slv_resp_o = slv_resp_q;
  assign dec_err_o  = dec_err_q;
  assign timeout_o  = timeout_q;
  assign busy_o     = (state_q != IDLE);

endmodule
